// File: rtl/rapcla_pkg.sv
// Shared types and elaboration helpers for the pipelined approximate CLA with
// error correction.
package rapcla_pkg;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        FIX = 1'b1
    } state_e;

    function automatic int calc_ng(input int size, input int groupsize);
        return size / groupsize;
    endfunction

    // Legal when groups tile the word and the window fits strictly inside a group.
    function automatic bit params_ok(input int size, input int groupsize, input int window);
        return (groupsize > 0) && (size % groupsize == 0) && (window >= 1) && (window < groupsize);
    endfunction

endpackage

// File: rtl/rapcla_ec_core.sv
// Combinational core: approximate and exact group-carry adders computed side by
// side from the same operands, plus the mismatch flag.
module rapcla_ec_core
    import rapcla_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int GROUPSIZE = 8,
    parameter int WINDOW    = 4
) (
    input  logic [SIZE-1:0]           a_i,
    input  logic [SIZE-1:0]           b_i,
    input  logic                      cin_i,
    input  logic [SIZE/GROUPSIZE-1:0] rcon_i,
    output logic [SIZE-1:0]           sum_apx_o,
    output logic                      cout_apx_o,
    output logic [SIZE-1:0]           sum_ex_o,
    output logic                      cout_ex_o,
    output logic                      err_o
);

    localparam int NG = calc_ng(SIZE, GROUPSIZE);

    if (!params_ok(SIZE, GROUPSIZE, WINDOW)) begin : g_bad_params
        $error("rapcla_ec_core: illegal SIZE/GROUPSIZE/WINDOW combination");
    end

    logic [SIZE-1:0] g;
    logic [SIZE-1:0] p;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        logic c_apx;
        logic c_ex;
        logic r_apx;
        logic r_ex;
        logic w;
        sum_apx_o = '0;
        sum_ex_o  = '0;
        c_apx     = cin_i;
        c_ex      = cin_i;
        r_apx     = 1'b0;
        r_ex      = 1'b0;
        w         = 1'b0;
        for (int gi = 0; gi < NG; gi++) begin
            r_apx = c_apx;
            r_ex  = c_ex;
            w     = 1'b0;
            for (int k = 0; k < GROUPSIZE; k++) begin
                sum_apx_o[gi*GROUPSIZE+k] = p[gi*GROUPSIZE+k] ^ r_apx;
                r_apx = g[gi*GROUPSIZE+k] | (p[gi*GROUPSIZE+k] & r_apx);
                sum_ex_o[gi*GROUPSIZE+k] = p[gi*GROUPSIZE+k] ^ r_ex;
                r_ex = g[gi*GROUPSIZE+k] | (p[gi*GROUPSIZE+k] & r_ex);
                // Window generate starts from a zero carry at the window's bottom bit.
                if (k >= GROUPSIZE - WINDOW) begin
                    w = g[gi*GROUPSIZE+k] | (p[gi*GROUPSIZE+k] & w);
                end
            end
            c_apx = rcon_i[gi] ? w : r_apx;
            c_ex  = r_ex;
        end
        cout_apx_o = c_apx;
        cout_ex_o  = c_ex;
    end

    assign err_o = ({cout_apx_o, sum_apx_o} != {cout_ex_o, sum_ex_o});

endmodule

// File: rtl/rapcla_pipe_ec.sv
// Two-stage valid/ready pipeline around the approximate adder core, with a
// one-cycle exact-correction bubble and a saturating error counter.
module rapcla_pipe_ec
    import rapcla_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int GROUPSIZE = 8,
    parameter int WINDOW    = 4,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SIZE-1:0]           a,
    input  logic [SIZE-1:0]           b,
    input  logic                      cin,
    input  logic [SIZE/GROUPSIZE-1:0] approx_rcon,
    input  logic                      auto_correct,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SIZE-1:0]           sum,
    output logic                      cout,
    output logic                      err_flag,
    output logic                      corrected,
    output logic [CNT_W-1:0]          err_cnt,
    input  logic                      clr_cnt
);

    localparam int NG = calc_ng(SIZE, GROUPSIZE);

    if (!params_ok(SIZE, GROUPSIZE, WINDOW)) begin : g_bad_params
        $error("rapcla_pipe_ec: illegal SIZE/GROUPSIZE/WINDOW combination");
    end

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never waits on ready, and S2 fields hold while out_valid & !out_ready.
    state_e            state_q, state_d;
    logic              s1_valid_q, s1_valid_d;
    logic [SIZE-1:0]   a_q, b_q;
    logic              cin_q, ac_q;
    logic [NG-1:0]     rcon_q;
    logic              ov_q, ov_d;
    logic [SIZE-1:0]   sum_q, sum_d;
    logic              cout_q, cout_d, err_q, err_d, corr_q, corr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [SIZE-1:0]   sum_apx, sum_ex;
    logic              cout_apx, cout_ex, core_err;
    logic              s2_can_load, go_fix, s2_load, accept, in_ready_c;

    rapcla_ec_core #(
        .SIZE      (SIZE),
        .GROUPSIZE (GROUPSIZE),
        .WINDOW    (WINDOW)
    ) u_core (
        .a_i        (a_q),
        .b_i        (b_q),
        .cin_i      (cin_q),
        .rcon_i     (rcon_q),
        .sum_apx_o  (sum_apx),
        .cout_apx_o (cout_apx),
        .sum_ex_o   (sum_ex),
        .cout_ex_o  (cout_ex),
        .err_o      (core_err)
    );

    always_comb begin
        s2_can_load = !ov_q | out_ready;
        go_fix      = (state_q == RUN) & s1_valid_q & core_err & ac_q & s2_can_load;
        // During FIX, S2 is always empty because the preceding cycle withheld its load.
        s2_load     = (state_q == FIX) |
                      ((state_q == RUN) & s1_valid_q & s2_can_load & !go_fix);
        state_d     = go_fix ? FIX : RUN;
        in_ready_c  = rst_n & (!s1_valid_q | s2_load) & (state_q == RUN) & !go_fix;
        accept      = in_valid & in_ready_c;
        s1_valid_d  = accept | (s1_valid_q & !s2_load);
        ov_d        = s2_load | (ov_q & !out_ready);
        sum_d       = (state_q == FIX) ? sum_ex  : sum_apx;
        cout_d      = (state_q == FIX) ? cout_ex : cout_apx;
        err_d       = (state_q == FIX) | core_err;
        corr_d      = (state_q == FIX);
        cnt_d       = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (s2_load && err_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            rcon_q     <= '0;
            ac_q       <= 1'b0;
            ov_q       <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            err_q      <= 1'b0;
            corr_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            ov_q       <= ov_d;
            cnt_q      <= cnt_d;
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                cin_q  <= cin;
                rcon_q <= approx_rcon;
                ac_q   <= auto_correct;
            end
            if (s2_load) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                err_q  <= err_d;
                corr_q <= corr_d;
            end
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = ov_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err_flag  = err_q;
    assign corrected = corr_q;
    assign err_cnt   = cnt_q;

endmodule
